// File: rtl/puf_keygen_ctrl.sv
// puf_keygen_ctrl: sequences repeated evaluations of an external delay-PUF
// array, majority-votes each response bit into a key and flags bits that
// disagreed across evaluations. One 8-bit page of the key is mirrored to LEDs.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | excite high, waiting for start
// ARM    | excite low for ARM_CYCLES cycles
// FIRE   | excite high (rising edge launches race), wait SETTLE_CYCLES
// SAMPLE | accumulate puf_resp into per-bit ones counters
// VOTE   | register key/unstable, pulse done
module puf_keygen_ctrl #(
    parameter int                N_BITS        = 32,
    parameter int                CHAL_W        = 32,
    parameter logic [CHAL_W-1:0] CHAL_A        = 32'h5A5A5A5A,
    parameter logic [CHAL_W-1:0] CHAL_B        = 32'hA5A5FFFF,
    parameter int                NUM_EVALS     = 5,
    parameter int                ARM_CYCLES    = 4,
    parameter int                SETTLE_CYCLES = 16,
    parameter int                PAGE_W        = (N_BITS / 8 > 1) ? $clog2(N_BITS / 8) : 1
) (
    input  logic              Clk,
    input  logic              RST,
    input  logic              start,
    input  logic              chal_sel,
    input  logic [PAGE_W-1:0] page_sel,
    output logic [CHAL_W-1:0] challenge,
    output logic              excite,
    input  logic [N_BITS-1:0] puf_resp,
    output logic [N_BITS-1:0] key,
    output logic [N_BITS-1:0] unstable,
    output logic              key_valid,
    output logic              busy,
    output logic              done,
    output logic [7:0]        leds
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ARM    = 3'd1;
    localparam logic [2:0] S_FIRE   = 3'd2;
    localparam logic [2:0] S_SAMPLE = 3'd3;
    localparam logic [2:0] S_VOTE   = 3'd4;

    localparam int CNT_W   = $clog2(NUM_EVALS + 1);
    localparam int TMR_MAX = (ARM_CYCLES > SETTLE_CYCLES) ? ARM_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX + 1) : 1;

    logic [2:0]        state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [CNT_W-1:0]  eval_q, eval_d;
    logic [CNT_W-1:0]  ones_q [N_BITS];
    logic [CNT_W-1:0]  ones_d [N_BITS];
    logic [CHAL_W-1:0] chal_q, chal_d;
    logic              excite_q, excite_d;
    logic [N_BITS-1:0] key_q, key_d;
    logic [N_BITS-1:0] unst_q, unst_d;
    logic              kv_q, kv_d;
    logic              done_q, done_d;
    logic [7:0]        leds_q, leds_d;

    // Sequencer: down-counting phase timer, evaluation count and vote.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        eval_d  = eval_q;
        ones_d  = ones_q;
        chal_d  = chal_q;
        key_d   = key_q;
        unst_d  = unst_q;
        kv_d    = kv_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    chal_d = chal_sel ? CHAL_A : CHAL_B;
                    eval_d = '0;
                    for (int i = 0; i < N_BITS; i++) ones_d[i] = '0;
                    kv_d    = 1'b0;
                    tmr_d   = TMR_W'(ARM_CYCLES - 1);
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (tmr_q == '0) begin
                    tmr_d   = TMR_W'(SETTLE_CYCLES - 1);
                    state_d = S_FIRE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_FIRE: begin
                if (tmr_q == '0) state_d = S_SAMPLE;
                else             tmr_d   = tmr_q - 1'b1;
            end
            S_SAMPLE: begin
                for (int i = 0; i < N_BITS; i++)
                    ones_d[i] = ones_q[i] + CNT_W'(puf_resp[i]);
                eval_d = eval_q + 1'b1;
                if (eval_q == CNT_W'(NUM_EVALS - 1)) begin
                    state_d = S_VOTE;
                end else begin
                    tmr_d   = TMR_W'(ARM_CYCLES - 1);
                    state_d = S_ARM;
                end
            end
            S_VOTE: begin
                for (int i = 0; i < N_BITS; i++) begin
                    key_d[i]  = {ones_q[i], 1'b0} > (CNT_W + 1)'(NUM_EVALS);
                    unst_d[i] = (ones_q[i] != '0) && (ones_q[i] != CNT_W'(NUM_EVALS));
                end
                kv_d    = 1'b1;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        excite_d = (state_d != S_ARM);
    end

    // LED page mux, built from next-state key so leds never lag key.
    always_comb begin
        leds_d = 8'h00;
        if (kv_d) begin
            for (int p = 0; p < N_BITS / 8; p++)
                if (page_sel == PAGE_W'(p)) leds_d = key_d[p*8 +: 8];
        end
    end

    // State and output registers.
    always_ff @(posedge Clk or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            tmr_q    <= '0;
            eval_q   <= '0;
            for (int i = 0; i < N_BITS; i++) ones_q[i] <= '0;
            chal_q   <= '1;
            excite_q <= 1'b1;
            key_q    <= '0;
            unst_q   <= '0;
            kv_q     <= 1'b0;
            done_q   <= 1'b0;
            leds_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            eval_q   <= eval_d;
            ones_q   <= ones_d;
            chal_q   <= chal_d;
            excite_q <= excite_d;
            key_q    <= key_d;
            unst_q   <= unst_d;
            kv_q     <= kv_d;
            done_q   <= done_d;
            leds_q   <= leds_d;
        end
    end

    assign challenge = chal_q;
    assign excite    = excite_q;
    assign key       = key_q;
    assign unstable  = unst_q;
    assign key_valid = kv_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign leds      = leds_q;

endmodule

// File: tb/tb_puf_keygen_ctrl.sv
// Testbench for puf_keygen_ctrl: default instance with randomized responses
// against a majority-vote reference model, plus a 64-bit single-eval instance.
module tb_puf_keygen_ctrl;

    localparam int TA = 4;
    localparam int TS = 16;
    localparam int TE = 5;
    localparam int TP = TA + TS + 1;
    localparam logic [31:0] CA = 32'h5A5A5A5A;
    localparam logic [31:0] CB = 32'hA5A5FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        chal_sel = 1'b0;
    logic [1:0]  page_sel = '0;
    logic [31:0] challenge;
    logic        excite;
    logic [31:0] puf_resp = '0;
    logic [31:0] key, unstable;
    logic        key_valid, busy, done;
    logic [7:0]  leds;

    logic        start2 = 1'b0;
    logic        chal_sel2 = 1'b0;
    logic [3:0]  page_sel2 = '0;
    logic [31:0] challenge2;
    logic        excite2;
    logic [63:0] puf_resp2 = '0;
    logic [63:0] key2, unstable2;
    logic        key_valid2, busy2, done2;
    logic [7:0]  leds2;

    int total = 0;
    int bad   = 0;
    logic [31:0] rs [TE];

    always #5 clk = ~clk;

    puf_keygen_ctrl dut (
        .Clk(clk), .RST(rst), .start(start), .chal_sel(chal_sel), .page_sel(page_sel),
        .challenge(challenge), .excite(excite), .puf_resp(puf_resp), .key(key),
        .unstable(unstable), .key_valid(key_valid), .busy(busy), .done(done), .leds(leds)
    );

    puf_keygen_ctrl #(.N_BITS(64), .NUM_EVALS(1), .ARM_CYCLES(1), .SETTLE_CYCLES(1), .PAGE_W(4)) dut2 (
        .Clk(clk), .RST(rst), .start(start2), .chal_sel(chal_sel2), .page_sel(page_sel2),
        .challenge(challenge2), .excite(excite2), .puf_resp(puf_resp2), .key(key2),
        .unstable(unstable2), .key_valid(key_valid2), .busy(busy2), .done(done2), .leds(leds2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // One complete key run from IDLE; called #1 after a rising edge.
    task automatic run_key(input bit cs, input bit hold, input bit noise, input int inj);
        logic [31:0] ek, eu;
        int n, cc;
        for (int i = 0; i < 32; i++) begin
            n = 0;
            for (int j = 0; j < TE; j++) n += rs[j][i];
            ek[i] = (2 * n > TE);
            eu[i] = (n != 0) && (n != TE);
        end
        start = 1'b1;
        chal_sel = cs;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        chk("chal", challenge, cs ? CA : CB);
        chk("kv_run", key_valid, 0);
        chk("busy0", busy, 1);
        chk("excite0", excite, 0);
        for (int c = 0; c <= TE * TP; c++) begin
            cc = c + 1;
            if ((cc % TP) == 0 && cc <= TE * TP) puf_resp = rs[cc / TP - 1];
            else if (noise) puf_resp = $urandom;
            if (noise) chal_sel = 1'($urandom);
            if (!hold && inj > 0 && c == inj - 1) start = 1'b1;
            if (!hold && inj > 0 && c == inj) start = 1'b0;
            @(posedge clk); #1;
            chk("excite", excite, (cc >= TE * TP) ? 1 : ((cc % TP) >= TA));
            chk("done", done, cc == TE * TP + 1);
            chk("busy", busy, cc <= TE * TP);
        end
        chk("key", key, ek);
        chk("unstable", unstable, eu);
        chk("key_valid", key_valid, 1);
        chk("chal_keep", challenge, cs ? CA : CB);
    endtask

    task automatic rand_rs();
        logic [31:0] base;
        base = $urandom;
        for (int j = 0; j < TE; j++) rs[j] = base ^ ($urandom & $urandom & $urandom);
    endtask

    initial begin
        logic [63:0] r2;
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_chal", challenge, 32'hFFFFFFFF);
        chk("rst_excite", excite, 1);
        chk("rst_key", key, 0);
        chk("rst_unst", unstable, 0);
        chk("rst_kv", key_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_leds", leds, 0);

        for (int j = 0; j < TE; j++) rs[j] = 32'hDEADBEEF;
        run_key(1, 0, 0, 0);
        chk("key_dead", key, 32'hDEADBEEF);
        page_sel = 2'd0; @(posedge clk); #1; chk("leds_p0", leds, 8'hEF);
        page_sel = 2'd1; @(posedge clk); #1; chk("leds_p1", leds, 8'hBE);
        page_sel = 2'd3; @(posedge clk); #1; chk("leds_p3", leds, 8'hDE);

        for (int j = 0; j < TE; j++)
            rs[j] = (32'h12345678 & ~32'h3) | {30'd0, (j == 2), (j % 2 == 0)};
        run_key(0, 0, 1, 0);
        chk("unst_pat", unstable, 32'h3);
        chk("key_pat", key[1:0], 2'b01);

        rand_rs();
        run_key(1'($urandom), 0, 1, 50);
        @(posedge clk); #1;
        chk("single_done", done, 0);
        chk("idle_after", busy, 0);

        rand_rs();
        run_key(1, 1, 1, 0);
        rand_rs();
        run_key(0, 0, 1, 0);

        rand_rs();
        start = 1'b1; chal_sel = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (59) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("mrst_chal", challenge, 32'hFFFFFFFF);
        chk("mrst_excite", excite, 1);
        chk("mrst_key", key, 0);
        chk("mrst_unst", unstable, 0);
        chk("mrst_kv", key_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_leds", leds, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("mrst_idle", busy, 0);
        run_key(0, 0, 1, 0);

        for (int t = 0; t < 3; t++) begin
            rand_rs();
            run_key(1'($urandom), 0, 1, 0);
        end

        for (int t = 0; t < 4; t++) begin
            r2 = {$urandom, $urandom};
            puf_resp2 = r2;
            start2 = 1'b1;
            @(posedge clk); #1;
            start2 = 1'b0;
            n = 0;
            for (int k = 1; k <= 20; k++) begin
                @(posedge clk); #1;
                if (done2) begin n = k; break; end
            end
            chk("lat2", n, 4);
            chk("key2", key2, r2);
            chk("unst2", unstable2, 0);
            chk("kv2", key_valid2, 1);
            page_sel2 = 4'd7; @(posedge clk); #1; chk("leds2_p7", leds2, r2[63:56]);
            page_sel2 = 4'd8; @(posedge clk); #1; chk("leds2_p8", leds2, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
